// File: rtl/pa_riscv.sv
// Shared RISC-V decode constants and the immediate beat carried through the decode pipe.
// Beat fields are sized for the widest legal XLEN; narrower pipes use the low bits.
package pa_riscv;

    localparam logic [6:0] LW         = 7'b0000011;
    localparam logic [6:0] SW         = 7'b0100011;
    localparam logic [6:0] R_TYPE_ALU = 7'b0110011;
    localparam logic [6:0] B_TYPE     = 7'b1100011;
    localparam logic [6:0] I_TYPE_ALU = 7'b0010011;
    localparam logic [6:0] LUI        = 7'b0110111;
    localparam logic [6:0] AUIPC      = 7'b0010111;
    localparam logic [6:0] JAL        = 7'b1101111;
    localparam logic [6:0] JALR       = 7'b1100111;

    localparam int BEAT_W = 64;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_t;

    typedef struct packed {
        logic [BEAT_W-1:0] imm;
        imm_type_t         immType;
        logic              illegal;
        logic [BEAT_W-1:0] pc;
    } imm_beat_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: selects the format from the opcode and
// sign-extends the assembled immediate from inst[31] up to XLEN.
module imm_decode
    import pa_riscv::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instruction,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_immType,
    output logic            o_illegal
);

    logic signed [31:0] w_raw;
    imm_type_t          w_type;
    logic [31:0]        w_ins;

    assign w_ins = i_instruction;

    always_comb begin
        w_raw     = '0;
        w_type    = IMM_NONE;
        o_illegal = 1'b0;
        case (w_ins[6:0])
            LW, I_TYPE_ALU, JALR: begin
                w_type = IMM_I;
                w_raw  = {{20{w_ins[31]}}, w_ins[31:20]};
            end
            SW: begin
                w_type = IMM_S;
                w_raw  = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
            end
            B_TYPE: begin
                w_type = IMM_B;
                w_raw  = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
            end
            LUI, AUIPC: begin
                w_type = IMM_U;
                w_raw  = {w_ins[31:12], 12'b0};
            end
            JAL: begin
                w_type = IMM_J;
                w_raw  = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
            end
            R_TYPE_ALU: ;
            default: o_illegal = 1'b1;
        endcase
    end

    // Every format carries inst[31] in bit 31, so a signed widen is the XLEN extension.
    assign o_imm     = XLEN'(w_raw);
    assign o_immType = w_type;

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered, valid/ready immediate generator for decode: one output register,
// plus an optional skid register so o_ready can come straight from a flop.
module imm_extend_pipe
    import pa_riscv::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instruction,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_immediateExtended,
    output logic [2:0]      o_immType,
    output logic            o_illegal,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_immType;
    logic            w_illegal;
    logic            w_in_xfer;
    imm_beat_t       w_beat_p0;
    imm_beat_t       r_out_p1;
    logic            r_vld_p1;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .i_instruction (i_instruction),
        .o_imm         (w_imm),
        .o_immType     (w_immType),
        .o_illegal     (w_illegal)
    );

    always_comb begin
        w_beat_p0                = '0;
        w_beat_p0.imm[XLEN-1:0]  = w_imm;
        w_beat_p0.immType        = imm_type_t'(w_immType);
        w_beat_p0.illegal        = w_illegal;
        w_beat_p0.pc[XLEN-1:0]   = i_pc;
    end

    assign w_in_xfer = i_valid && o_ready;

    // ---- stage p0 -> p1: output register (and skid register when enabled) ----
    generate
        if (SKID != 0) begin : g_skid
            imm_beat_t r_skid_p1;
            logic      r_skid_vld_p1;

            assign o_ready = !r_skid_vld_p1;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_vld_p1      <= 1'b0;
                    r_out_p1      <= '0;
                    r_skid_vld_p1 <= 1'b0;
                    r_skid_p1     <= '0;
                end else if (!r_vld_p1 || i_ready) begin
                    // Output slot frees up: the older skid beat has priority over new input.
                    if (r_skid_vld_p1) begin
                        r_out_p1      <= r_skid_p1;
                        r_vld_p1      <= 1'b1;
                        r_skid_vld_p1 <= 1'b0;
                    end else begin
                        r_vld_p1 <= w_in_xfer;
                        if (w_in_xfer) r_out_p1 <= w_beat_p0;
                    end
                end else if (w_in_xfer) begin
                    r_skid_p1     <= w_beat_p0;
                    r_skid_vld_p1 <= 1'b1;
                end
            end
        end else begin : g_noskid
            assign o_ready = !r_vld_p1 || i_ready;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_vld_p1 <= 1'b0;
                    r_out_p1 <= '0;
                end else if (o_ready) begin
                    r_vld_p1 <= i_valid;
                    if (i_valid) r_out_p1 <= w_beat_p0;
                end
            end
        end

        if (XLEN < BEAT_W) begin : g_narrow
            logic w_unused_hi;
            assign w_unused_hi = ^{r_out_p1.imm[BEAT_W-1:XLEN], r_out_p1.pc[BEAT_W-1:XLEN]};
        end
    endgenerate

    assign o_valid             = r_vld_p1;
    assign o_immediateExtended = r_out_p1.imm[XLEN-1:0];
    assign o_immType           = r_out_p1.immType;
    assign o_illegal           = r_out_p1.illegal;
    assign o_pc                = r_out_p1.pc[XLEN-1:0];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: a 32-bit skid instance and a 64-bit no-skid instance,
// checked against an arithmetic immediate model and a per-instance beat queue.
module tb_imm_extend_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_iv, a_ordy, a_ov, a_ir, a_ill;
    logic [31:0] a_inst, a_pc, a_opc, a_imm;
    logic [2:0]  a_typ;

    logic        b_iv, b_ordy, b_ov, b_ir, b_ill;
    logic [31:0] b_inst;
    logic [63:0] b_pc, b_opc, b_imm;
    logic [2:0]  b_typ;

    imm_extend_pipe #(.XLEN(32), .SKID(1)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(a_iv), .o_ready(a_ordy),
        .i_instruction(a_inst), .i_pc(a_pc), .o_valid(a_ov), .i_ready(a_ir),
        .o_immediateExtended(a_imm), .o_immType(a_typ), .o_illegal(a_ill), .o_pc(a_opc)
    );

    imm_extend_pipe #(.XLEN(64), .SKID(0)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(b_iv), .o_ready(b_ordy),
        .i_instruction(b_inst), .i_pc(b_pc), .o_valid(b_ov), .i_ready(b_ir),
        .o_immediateExtended(b_imm), .o_immType(b_typ), .o_illegal(b_ill), .o_pc(b_opc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
        logic [63:0] pc;
    } exp_t;

    function automatic longint sx(input longint u, input int w);
        return (u >= (longint'(1) << (w - 1))) ? u - (longint'(1) << w) : u;
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
        exp_t   e;
        longint v;
        v     = 0;
        e.typ = 3'd0;
        e.ill = 1'b0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: begin e.typ = 3'd1; v = sx(longint'(ins[31:20]), 12); end
            7'h23: begin e.typ = 3'd2; v = sx(longint'({ins[31:25], ins[11:7]}), 12); end
            7'h63: begin e.typ = 3'd3; v = 2 * sx(longint'({ins[31], ins[7], ins[30:25], ins[11:8]}), 12); end
            7'h37, 7'h17: begin e.typ = 3'd4; v = 4096 * sx(longint'(ins[31:12]), 20); end
            7'h6F: begin e.typ = 3'd5; v = 2 * sx(longint'({ins[31], ins[19:12], ins[20], ins[30:21]}), 20); end
            7'h33: ;
            default: e.ill = 1'b1;
        endcase
        e.imm = v;
        e.pc  = pc;
        if (xlen == 32) begin
            e.imm = e.imm & 64'hFFFF_FFFF;
            e.pc  = e.pc & 64'hFFFF_FFFF;
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] r;
        logic [6:0]  ops [10];
        ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 9)];
        return r;
    endfunction

    // Scoreboard: one queue of accepted-but-not-delivered beats per instance.
    exp_t        mq [2][$];
    int          n_out [2];
    logic        p_ov [2], p_ir [2], p_ill [2];
    logic [63:0] p_imm [2], p_pc [2];
    logic [2:0]  p_typ [2];
    logic        p_rst;

    initial begin
        for (int k = 0; k < 2; k++) begin
            n_out[k] = 0; p_ov[k] = 1'b0; p_ir[k] = 1'b0;
        end
        p_rst = 1'b1;
    end

    task automatic mon(input int k, input int skid, input int xlen, input logic iv, input logic ordy,
                       input logic ov, input logic ir, input logic [31:0] inst, input logic [63:0] pc,
                       input logic [63:0] imm, input logic [2:0] typ, input logic ill);
        int   held;
        exp_t e;
        held = mq[k].size();
        if (rst) begin
            mq[k].delete();
        end else begin
            chk($sformatf("m%0d o_valid", k), ov, held > 0);
            if (skid != 0) chk($sformatf("m%0d o_ready", k), ordy, held < 2);
            else           chk($sformatf("m%0d o_ready", k), ordy, (held == 0) || ir);
            if (p_ov[k] && !p_ir[k] && !p_rst) begin
                chk($sformatf("m%0d hold imm", k), imm, p_imm[k]);
                chk($sformatf("m%0d hold pc", k), pc === pc ? {p_pc[k]} : 64'h0, p_pc[k]);
                chk($sformatf("m%0d hold type", k), typ, p_typ[k]);
                chk($sformatf("m%0d hold ill", k), ill, p_ill[k]);
            end
            if (ov && ir) begin
                if (held == 0) begin
                    chk($sformatf("m%0d spurious beat", k), 1, 0);
                end else begin
                    e = mq[k].pop_front();
                    n_out[k]++;
                    chk($sformatf("m%0d imm", k), imm, e.imm);
                    chk($sformatf("m%0d type", k), typ, e.typ);
                    chk($sformatf("m%0d illegal", k), ill, e.ill);
                end
            end
            if (iv && ordy) mq[k].push_back(model(inst, {32'b0, inst} & 64'h0 | pc, xlen));
        end
        p_ov[k] = ov; p_ir[k] = ir; p_imm[k] = imm; p_typ[k] = typ; p_ill[k] = ill;
    endtask

    // Output pc is checked against the accepted pc through the beat queue as well.
    exp_t pc_q [2][$];

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pc_q[0].delete(); pc_q[1].delete();
        end else begin
            if (a_ov && a_ir && pc_q[0].size() > 0) begin
                e = pc_q[0].pop_front();
                chk("m0 pc", {32'b0, a_opc}, e.pc);
            end
            if (b_ov && b_ir && pc_q[1].size() > 0) begin
                e = pc_q[1].pop_front();
                chk("m1 pc", b_opc, e.pc);
            end
            if (a_iv && a_ordy) pc_q[0].push_back(model(a_inst, {32'b0, a_pc}, 32));
            if (b_iv && b_ordy) pc_q[1].push_back(model(b_inst, b_pc, 64));
        end
        mon(0, 1, 32, a_iv, a_ordy, a_ov, a_ir, a_inst, {32'b0, a_pc}, {32'b0, a_imm}, a_typ, a_ill);
        mon(1, 0, 64, b_iv, b_ordy, b_ov, b_ir, b_inst, b_pc, b_imm, b_typ, b_ill);
        p_pc[0] = {32'b0, a_opc};
        p_pc[1] = b_opc;
        p_rst   = rst;
    end

    task automatic a_one(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] ei, input logic [2:0] et, input logic el);
        @(posedge clk); #1;
        a_ir = 1'b1; a_iv = 1'b1; a_inst = ins; a_pc = pc;
        @(posedge clk); #1;
        a_iv = 1'b0;
        @(negedge clk);
        chk({tag, " valid"}, a_ov, 1'b1);
        chk({tag, " imm"}, a_imm, ei);
        chk({tag, " type"}, a_typ, et);
        chk({tag, " illegal"}, a_ill, el);
        chk({tag, " pc"}, a_opc, pc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog n_checks=%0d required=finish", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] bp [4];
        rst = 1'b1;
        a_iv = 1'b0; a_ir = 1'b1; a_inst = '0; a_pc = '0;
        b_iv = 1'b0; b_ir = 1'b1; b_inst = '0; b_pc = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst a valid", a_ov, 1'b0);
        chk("rst a ready", a_ordy, 1'b1);
        chk("rst a imm", a_imm, 32'h0);
        chk("rst a pc", a_opc, 32'h0);
        chk("rst a type", a_typ, 3'd0);
        chk("rst b valid", b_ov, 1'b0);
        chk("rst b ready", b_ordy, 1'b1);

        a_one("I addi", 32'hFFF00093, 32'h0000_0100, 32'hFFFF_FFFF, 3'd1, 1'b0);
        a_one("S sw",   32'hFE112E23, 32'h0000_0104, 32'hFFFF_FFFC, 3'd2, 1'b0);
        a_one("B beq",  32'hFE000CE3, 32'h0000_0108, 32'hFFFF_FFF8, 3'd3, 1'b0);
        a_one("J jal",  32'h001000EF, 32'h0000_010C, 32'h0000_0800, 3'd5, 1'b0);
        a_one("illeg",  32'h0000007F, 32'hDEAD_0000, 32'h0000_0000, 3'd0, 1'b1);
        a_one("R add",  32'h00000033, 32'h0000_0110, 32'h0000_0000, 3'd0, 1'b0);
        a_one("U lui32", 32'h800000B7, 32'h0000_0114, 32'h8000_0000, 3'd4, 1'b0);

        @(posedge clk); #1;
        b_iv = 1'b1; b_inst = 32'h800000B7; b_pc = 64'h1234_5678_9ABC_DEF0;
        @(posedge clk); #1;
        b_iv = 1'b0;
        @(negedge clk);
        chk("U64 valid", b_ov, 1'b1);
        chk("U64 imm", b_imm, 64'hFFFF_FFFF_8000_0000);
        chk("U64 type", b_typ, 3'd4);
        chk("U64 illegal", b_ill, 1'b0);
        chk("U64 pc", b_opc, 64'h1234_5678_9ABC_DEF0);

        // Backpressure: i_ready low for cycles 2-4 while four beats stream in.
        bp = '{32'h00500113, 32'hFFC10093, 32'h00112023, 32'h123450B7};
        base = n_out[0];
        @(posedge clk); #1;
        fork
            begin
                for (int j = 0; j < 4; j++) begin
                    int w;
                    a_iv = 1'b1; a_inst = bp[j]; a_pc = 32'h200 + 32'(j * 4);
                    w = 0;
                    while (1) begin
                        @(negedge clk);
                        if (a_ordy) break;
                        w++;
                        if (w > 20) begin chk("bp accept timeout", 0, 1); break; end
                    end
                    @(posedge clk); #1;
                end
                a_iv = 1'b0;
            end
            begin
                for (int c = 1; c <= 10; c++) begin
                    a_ir = !(c >= 2 && c <= 4);
                    @(negedge clk);
                    if (c == 2) chk("bp ready one held", a_ordy, 1'b1);
                    if (c == 3) chk("bp ready two held", a_ordy, 1'b0);
                    if (c == 4) chk("bp stall ready", a_ordy, 1'b0);
                    if (c >= 5 && c <= 8) chk($sformatf("bp stream c%0d", c), a_ov, 1'b1);
                    @(posedge clk); #1;
                end
            end
        join
        chk("bp delivered", n_out[0] - base, 4);

        // Reset with two beats held: neither may come out afterwards.
        a_ir = 1'b0; a_iv = 1'b1; a_inst = 32'h00100093; a_pc = 32'h300;
        @(posedge clk); #1;
        a_inst = 32'h00200093; a_pc = 32'h304;
        @(posedge clk); #1;
        a_iv = 1'b0;
        @(negedge clk);
        chk("pre-rst ready", a_ordy, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; a_ir = 1'b1;
        @(negedge clk);
        chk("post-rst valid", a_ov, 1'b0);
        chk("post-rst ready", a_ordy, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("post-rst no replay", a_ov, 1'b0);
        end
        a_one("after rst", 32'h00A00513, 32'h0000_0400, 32'h0000_000A, 3'd1, 1'b0);

        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk); #1;
                    a_iv = ($urandom_range(0, 3) != 0);
                    a_ir = ($urandom_range(0, 3) != 0);
                    a_inst = rnd_inst();
                    a_pc = $urandom;
                end
                a_iv = 1'b0; a_ir = 1'b1;
            end
            begin
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk); #1;
                    b_iv = ($urandom_range(0, 3) != 0);
                    b_ir = ($urandom_range(0, 3) != 0);
                    b_inst = rnd_inst();
                    b_pc = {$urandom, $urandom};
                end
                b_iv = 1'b0; b_ir = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("drain a", mq[0].size(), 0);
        chk("drain b", mq[1].size(), 0);
        chk("rand a delivered", n_out[0] > base + 100, 1'b1);
        chk("rand b delivered", n_out[1] > 100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
